// File: rtl/dmni_latency_monitor_if.sv
// Record stream carrying one latency record per transfer.
//
// Handshake: the producer raises rec_valid_o while a record is presented and
// holds every rec_* field stable until the consumer raises rec_ready_i. A
// record is transferred on each clock edge where both are high.
//
// Signals:
//   rec_valid_o  head record present
//   rec_ready_i  consumer accepts head
//   rec_ch_o     source channel
//   rec_prod_o   producer id
//   rec_cons_o   consumer id
//   rec_total_o  eop tick - send timestamp
//   rec_noc_o    header tick - send timestamp
//   rec_size_o   packet length in flits, header included
// Modports: master = monitor side, slave = record consumer.
interface dmni_latency_monitor_if #(
  parameter int FLIT_SIZE = 32,
  parameter int CH_W      = 1
);
  logic                 rec_valid_o;
  logic                 rec_ready_i;
  logic [CH_W-1:0]      rec_ch_o;
  logic [FLIT_SIZE-1:0] rec_prod_o;
  logic [FLIT_SIZE-1:0] rec_cons_o;
  logic [63:0]          rec_total_o;
  logic [63:0]          rec_noc_o;
  logic [FLIT_SIZE-1:0] rec_size_o;

  modport master (
    output rec_valid_o, rec_ch_o, rec_prod_o, rec_cons_o,
           rec_total_o, rec_noc_o, rec_size_o,
    input  rec_ready_i
  );

  modport slave (
    input  rec_valid_o, rec_ch_o, rec_prod_o, rec_cons_o,
           rec_total_o, rec_noc_o, rec_size_o,
    output rec_ready_i
  );
endinterface

// File: rtl/dmni_latency_monitor.sv
// Multi-channel DMNI latency monitor.
//
// Snoops NUM_CH DMNI receive links, parses each packet header at fixed flit
// indices and, for every packet whose service passes the filter, produces a
// record with total latency (eop tick - timestamp) and NoC latency (header
// tick - timestamp). Each channel owns a 1-entry staging register; a
// round-robin arbiter moves staged records into a shared FIFO that is drained
// over the record stream interface.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   tx_i/eop_i/credit_i per-link flit valid / last flit / credit
//   data_i              per-link flit data, channel c at [c*FLIT_SIZE +: FLIT_SIZE]
//   tick_cntr_i         global tick counter
//   filter_en_i         1 = record matching service only, 0 = record all
//   filter_service_i    service value to match
//   rec                 record stream (master side)
//   pkt_cnt_o           matched packets per channel (32 bit, wrapping)
//   drop_cnt_o          dropped records per channel (16 bit, saturating)
//   max_total_o         largest total latency per channel (64 bit)
//   dbg_state_o         parser state per channel (1 = PAYLOAD)
module dmni_latency_monitor #(
  parameter int FLIT_SIZE     = 32,
  parameter int NUM_CH        = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int SERVICE_IDX   = 2,
  parameter int PRODUCER_IDX  = 3,
  parameter int CONSUMER_IDX  = 4,
  parameter int TIMESTAMP_IDX = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CH-1:0]             tx_i,
  input  logic [NUM_CH-1:0]             eop_i,
  input  logic [NUM_CH-1:0]             credit_i,
  input  logic [NUM_CH*FLIT_SIZE-1:0]   data_i,
  input  logic [63:0]                   tick_cntr_i,
  input  logic                          filter_en_i,
  input  logic [FLIT_SIZE-1:0]          filter_service_i,
  dmni_latency_monitor_if.master        rec,
  output logic [NUM_CH*32-1:0]          pkt_cnt_o,
  output logic [NUM_CH*16-1:0]          drop_cnt_o,
  output logic [NUM_CH*64-1:0]          max_total_o,
  output logic [NUM_CH-1:0]             dbg_state_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [FLIT_SIZE-1:0] L_ONE  = FLIT_SIZE'(1);
  localparam logic [FLIT_SIZE-1:0] L_SVC  = FLIT_SIZE'(SERVICE_IDX);
  localparam logic [FLIT_SIZE-1:0] L_PROD = FLIT_SIZE'(PRODUCER_IDX);
  localparam logic [FLIT_SIZE-1:0] L_CONS = FLIT_SIZE'(CONSUMER_IDX);
  localparam logic [FLIT_SIZE-1:0] L_TS   = FLIT_SIZE'(TIMESTAMP_IDX);

  typedef enum logic {S_HEADER = 1'b0, S_PAYLOAD = 1'b1} state_t;

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [FLIT_SIZE-1:0] prod;
    logic [FLIT_SIZE-1:0] cons;
    logic [63:0]          total;
    logic [63:0]          noc;
    logic [FLIT_SIZE-1:0] size;
  } rec_t;

  // Staging view shared with the arbiter
  logic [NUM_CH-1:0] w_stg_vld;
  rec_t              w_stg_arr [NUM_CH];
  logic [NUM_CH-1:0] w_grant;

  // ---------------------------------------------------------------------------
  // Per-channel parser, staging register and statistics
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [FLIT_SIZE-1:0] w_data;
    logic                 w_hs;
    logic [FLIT_SIZE-1:0] w_svc, w_prod, w_cons, w_ts;
    logic [63:0]          w_ts64;
    logic [63:0]          w_total, w_noc;
    logic                 w_match;
    logic                 w_done;
    rec_t                 w_rec;

    state_t               r_state;
    logic [FLIT_SIZE-1:0] r_idx;
    logic [63:0]          r_hdr_tick;
    logic [FLIT_SIZE-1:0] r_svc, r_prod, r_cons, r_ts;

    logic                 r_stg_vld;
    rec_t                 r_stg;
    logic [31:0]          r_pkt;
    logic [15:0]          r_drop;
    logic [63:0]          r_max;

    assign w_data = data_i[c*FLIT_SIZE +: FLIT_SIZE];
    assign w_hs   = tx_i[c] & credit_i[c];

    // Fields captured in this very handshake must be visible to the
    // completion logic (e.g. the timestamp flit carrying eop).
    assign w_svc  = (r_idx == L_SVC)  ? w_data : r_svc;
    assign w_prod = (r_idx == L_PROD) ? w_data : r_prod;
    assign w_cons = (r_idx == L_CONS) ? w_data : r_cons;
    assign w_ts   = (r_idx == L_TS)   ? w_data : r_ts;

    // Unsigned modulo-2^64 differences; wrap yields the true distance.
    assign w_ts64  = 64'(w_ts);
    assign w_total = tick_cntr_i - w_ts64;
    assign w_noc   = r_hdr_tick - w_ts64;

    assign w_match = ~filter_en_i | (w_svc == filter_service_i);
    assign w_done  = w_hs & eop_i[c] & (r_state == S_PAYLOAD) &
                     (r_idx >= L_TS) & w_match;

    always_comb begin
      w_rec       = '0;
      w_rec.ch    = CH_W'(c);
      w_rec.prod  = w_prod;
      w_rec.cons  = w_cons;
      w_rec.total = w_total;
      w_rec.noc   = w_noc;
      w_rec.size  = r_idx + L_ONE;
    end

    // Parser FSM: r_idx holds the index of the flit expected next.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state    <= S_HEADER;
        r_idx      <= '0;
        r_hdr_tick <= '0;
        r_svc      <= '0;
        r_prod     <= '0;
        r_cons     <= '0;
        r_ts       <= '0;
      end else if (w_hs) begin
        case (r_state)
          S_HEADER: begin
            // A single-flit packet (header with eop) is ignored.
            if (!eop_i[c]) begin
              r_state    <= S_PAYLOAD;
              r_idx      <= L_ONE;
              r_hdr_tick <= tick_cntr_i;
            end
          end
          S_PAYLOAD: begin
            if (r_idx == L_SVC)  r_svc  <= w_data;
            if (r_idx == L_PROD) r_prod <= w_data;
            if (r_idx == L_CONS) r_cons <= w_data;
            if (r_idx == L_TS)   r_ts   <= w_data;
            r_idx <= r_idx + L_ONE;
            if (eop_i[c]) r_state <= S_HEADER;
          end
          default: r_state <= S_HEADER;
        endcase
      end
    end

    // Staging and statistics. A staged record granted this cycle frees the
    // slot in time for a same-cycle completion, so that case is not a drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_stg_vld <= 1'b0;
        r_stg     <= '0;
        r_pkt     <= '0;
        r_drop    <= '0;
        r_max     <= '0;
      end else begin
        if (w_done) begin
          r_pkt <= r_pkt + 32'd1;
          if (w_total > r_max) r_max <= w_total;
          if (r_stg_vld && !w_grant[c]) begin
            if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
          end else begin
            r_stg_vld <= 1'b1;
            r_stg     <= w_rec;
          end
        end else if (w_grant[c]) begin
          r_stg_vld <= 1'b0;
        end
      end
    end

    assign w_stg_vld[c]              = r_stg_vld;
    assign w_stg_arr[c]              = r_stg;
    assign pkt_cnt_o[c*32 +: 32]     = r_pkt;
    assign drop_cnt_o[c*16 +: 16]    = r_drop;
    assign max_total_o[c*64 +: 64]   = r_max;
    assign dbg_state_o[c]            = (r_state == S_PAYLOAD);
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: search from last grant + 1, wrapping to 0.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] r_last;
  logic            w_full;
  logic            w_push;
  logic [CH_W-1:0] w_gnt_idx;
  rec_t            w_push_rec;

  always_comb begin
    w_grant    = '0;
    w_push     = 1'b0;
    w_gnt_idx  = '0;
    w_push_rec = '0;
    if (!w_full) begin
      // First pass: channels above the last grant.
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_push && w_stg_vld[c] && (c > int'(r_last))) begin
          w_push     = 1'b1;
          w_grant[c] = 1'b1;
          w_gnt_idx  = CH_W'(c);
          w_push_rec = w_stg_arr[c];
        end
      end
      // Second pass: wrap around to channel 0 .. last grant.
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_push && w_stg_vld[c] && (c <= int'(r_last))) begin
          w_push     = 1'b1;
          w_grant[c] = 1'b1;
          w_gnt_idx  = CH_W'(c);
          w_push_rec = w_stg_arr[c];
        end
      end
    end
  end

  // Reset to the highest channel so the first search starts at channel 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_last <= CH_W'(NUM_CH - 1);
    else if (w_push) r_last <= w_gnt_idx;
  end

  // ---------------------------------------------------------------------------
  // Record FIFO. Full is taken from the registered count, so a pop in the
  // same cycle does not make room for a push.
  // ---------------------------------------------------------------------------
  rec_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  rec_t          w_head;

  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) & rec.rec_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_push_rec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Fields read as zero whenever the FIFO is empty.
  assign w_head = (r_cnt != '0) ? r_mem[r_rptr] : '0;

  assign rec.rec_valid_o = (r_cnt != '0);
  assign rec.rec_ch_o    = w_head.ch;
  assign rec.rec_prod_o  = w_head.prod;
  assign rec.rec_cons_o  = w_head.cons;
  assign rec.rec_total_o = w_head.total;
  assign rec.rec_noc_o   = w_head.noc;
  assign rec.rec_size_o  = w_head.size;

endmodule
